// File: rtl/smu_cfg_pkg.sv
// Shared types and CRC-8 helper for the SMU configuration stream loader.
package smu_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } cfg_ld_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One serial CRC-8 step; the incoming bit is XORed into the MSB feedback.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    crc8_step = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/smu_cfg_stream_loader_if.sv
// Beat stream and committed-config bundle between a bitstream source and the loader.
interface smu_cfg_stream_loader_if #(
  parameter int LANE_W   = 1,
  parameter int CFG_SIZE = 100
);

  logic                StreamStart;
  logic [LANE_W-1:0]   SerialIn;
  logic                StreamValid;
  logic                StreamReady;
  logic [CFG_SIZE-1:0] ParallelOut;
  logic                CfgDone;
  logic                CfgError;

  modport master (
    output StreamStart,
    output SerialIn,
    output StreamValid,
    input  StreamReady,
    input  ParallelOut,
    input  CfgDone,
    input  CfgError
  );

  modport slave (
    input  StreamStart,
    input  SerialIn,
    input  StreamValid,
    output StreamReady,
    output ParallelOut,
    output CfgDone,
    output CfgError
  );

endinterface

// File: rtl/smu_cfg_crc8.sv
// Per-beat CRC-8 accumulator: folds LANE_W bits per enabled cycle, MSB (earliest) first.
module smu_cfg_crc8
  import smu_cfg_pkg::*;
#(
  parameter int LANE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [LANE_W-1:0] data_i,
  output logic [7:0]        crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic [7:0] step_s;

  // Next CRC value: clear wins over a beat update.
  always_comb begin
    step_s = crc_q;
    for (int i = LANE_W - 1; i >= 0; i--) begin
      step_s = crc8_step(step_s, data_i[i]);
    end
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = 8'h00;
    end else if (en_i) begin
      crc_d = step_s;
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/smu_cfg_stream_loader.sv
// Handshaked multi-lane config loader; frames are committed atomically to ParallelOut.
// Optional CRC-8 trailer check is enabled by defining SMU_CFG_CRC_EN.
module smu_cfg_stream_loader
  import smu_cfg_pkg::*;
#(
  parameter int CFG_SIZE = 100,
  parameter int LANE_W   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  smu_cfg_stream_loader_if.slave bus
);

  localparam int NUM_BEATS = CFG_SIZE / LANE_W;
  localparam int CNT_W     = $clog2(NUM_BEATS + 1);

  if ((CFG_SIZE % LANE_W) != 0) begin : g_size_chk
    $fatal(1, "CFG_SIZE must be a multiple of LANE_W");
  end

  cfg_ld_state_e       state_q;
  cfg_ld_state_e       state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [CFG_SIZE-1:0] shadow_q;
  logic [CFG_SIZE-1:0] shadow_d;
  logic [CFG_SIZE-1:0] par_q;
  logic [CFG_SIZE-1:0] par_d;
  logic                done_q;
  logic                done_d;
  logic                err_q;
  logic                err_d;
  logic                ready_s;
  logic                accept_s;
  logic                last_beat_s;
  logic [CFG_SIZE-1:0] shadow_nx_s;

`ifdef SMU_CFG_CRC_EN
  localparam int CRC_BEATS = (8 + LANE_W - 1) / LANE_W;
  localparam int RX_W      = CRC_BEATS * LANE_W;
  localparam int CCNT_W    = $clog2(CRC_BEATS + 1);

  logic [RX_W-1:0]   rx_q;
  logic [RX_W-1:0]   rx_d;
  logic [RX_W-1:0]   rx_nx_s;
  logic [CCNT_W-1:0] ccnt_q;
  logic [CCNT_W-1:0] ccnt_d;
  logic              crc_clr_s;
  logic              crc_en_s;
  logic              crc_last_s;
  logic [7:0]        crc_s;

  smu_cfg_crc8 #(.LANE_W(LANE_W)) u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (crc_clr_s),
    .en_i   (crc_en_s),
    .data_i (bus.SerialIn),
    .crc_o  (crc_s)
  );

  assign rx_nx_s    = (rx_q << LANE_W) | RX_W'(bus.SerialIn);
  assign crc_last_s = (ccnt_q == CCNT_W'(CRC_BEATS - 1));
`endif

  // A start pulse always masks the same-cycle beat.
  assign ready_s     = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) && !bus.StreamStart;
  assign accept_s    = bus.StreamValid && ready_s;
  assign last_beat_s = (cnt_q == CNT_W'(NUM_BEATS - 1));
  assign shadow_nx_s = (shadow_q << LANE_W) | CFG_SIZE'(bus.SerialIn);

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    par_d    = par_q;
    done_d   = done_q;
    err_d    = err_q;
`ifdef SMU_CFG_CRC_EN
    rx_d      = rx_q;
    ccnt_d    = ccnt_q;
    crc_clr_s = 1'b0;
    crc_en_s  = 1'b0;
`endif
    if (bus.StreamStart) begin
      state_d  = ST_LOAD;
      cnt_d    = {CNT_W{1'b0}};
      shadow_d = {CFG_SIZE{1'b0}};
      done_d   = 1'b0;
      err_d    = 1'b0;
`ifdef SMU_CFG_CRC_EN
      rx_d      = {RX_W{1'b0}};
      ccnt_d    = {CCNT_W{1'b0}};
      crc_clr_s = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_LOAD: begin
          if (accept_s) begin
            shadow_d = shadow_nx_s;
            cnt_d    = cnt_q + CNT_W'(1);
`ifdef SMU_CFG_CRC_EN
            crc_en_s = 1'b1;
`endif
            if (last_beat_s) begin
`ifdef SMU_CFG_CRC_EN
              state_d = ST_CHECK;
`else
              par_d   = shadow_nx_s;
              done_d  = 1'b1;
              state_d = ST_DONE;
`endif
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
`ifdef SMU_CFG_CRC_EN
        ST_CHECK: begin
          if (accept_s) begin
            rx_d   = rx_nx_s;
            ccnt_d = ccnt_q + CCNT_W'(1);
            if (crc_last_s) begin
              // Shadow already holds the full frame; commit only on a CRC match.
              if (rx_nx_s[7:0] == crc_s) begin
                par_d   = shadow_q;
                done_d  = 1'b1;
                state_d = ST_DONE;
              end else begin
                err_d   = 1'b1;
                done_d  = 1'b0;
                state_d = ST_ERR;
              end
            end else begin
              state_d = ST_CHECK;
            end
          end else begin
            state_d = ST_CHECK;
          end
        end
`endif
        ST_DONE: begin
          if (bus.StreamValid) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
        ST_ERR: begin
          err_d  = 1'b1;
          done_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Loader state, shadow and committed-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      shadow_q <= {CFG_SIZE{1'b0}};
      par_q    <= {CFG_SIZE{1'b0}};
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      par_q    <= par_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef SMU_CFG_CRC_EN
  // Received-CRC shift register and CRC beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q   <= {RX_W{1'b0}};
      ccnt_q <= {CCNT_W{1'b0}};
    end else begin
      rx_q   <= rx_d;
      ccnt_q <= ccnt_d;
    end
  end
`endif

  assign bus.StreamReady = ready_s;
  assign bus.ParallelOut = par_q;
  assign bus.CfgDone     = done_q;
  assign bus.CfgError    = err_q;

endmodule
